// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register: full result bundle, valid/ready handshake with a 2-entry skid buffer.
// Optional performance counters (stall_cnt, bubble_cnt) enabled by defining MEM_WB_PERF_CNT_EN.
module mem_wb_pipe_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     instr_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     alu_res_in,
    input  logic [DATA_W-1:0]     mem_data_in,
    input  logic                  wb_en_in,
    input  logic                  mem_to_reg_in,
    input  logic [REG_ADDR_W-1:0] wb_dest_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     instr,
    output logic [DATA_W-1:0]     pc,
    output logic [DATA_W-1:0]     alu_res,
    output logic [DATA_W-1:0]     mem_data,
    output logic                  wb_en,
    output logic                  mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_dest
`ifdef MEM_WB_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           bubble_cnt
`endif
);

    localparam int BW = 4 * DATA_W + 2 + REG_ADDR_W;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [BW-1:0] main_q;
    logic [BW-1:0] skid_q;
    logic [BW-1:0] in_bundle;
    logic [BW-1:0] out_bundle;
    logic          in_ready_q;
    logic          acc;
    logic          drn;
    logic          load_main_in;
    logic          load_main_skid;
    logic          load_skid;

    assign in_bundle = {instr_in, pc_in, alu_res_in, mem_data_in,
                        wb_en_in, mem_to_reg_in, wb_dest_in};

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign acc       = in_valid & in_ready_q;
    assign drn       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            // Flush drops any incoming bundle; a same-cycle drain needs no action since all is emptied.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        load_main_in = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && drn) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        load_skid = 1'b1;
                        state_d   = ST_TWO;
                    end else if (drn) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drn) begin
                        load_main_skid = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_main_in) begin
                main_q <= in_bundle;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_bundle;
            end
        end
    end

    // Stale main contents are masked so an empty stage presents a NOP with wb_en low.
    assign out_bundle = out_valid ? main_q : '0;
    assign {instr, pc, alu_res, mem_data, wb_en, mem_to_reg, wb_dest} = out_bundle;

`ifdef MEM_WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!out_valid && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Bench for mem_wb_pipe_reg: depth-2 FIFO reference model checked every cycle plus directed literal checks.
// Counter checks are compiled in when MEM_WB_PERF_CNT_EN is defined.
module tb_mem_wb_pipe_reg;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int BW = 4 * DW + 2 + AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] instr_in = '0;
    logic [DW-1:0] pc_in = '0;
    logic [DW-1:0] alu_res_in = '0;
    logic [DW-1:0] mem_data_in = '0;
    logic          wb_en_in = 1'b0;
    logic          mem_to_reg_in = 1'b0;
    logic [AW-1:0] wb_dest_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] instr;
    logic [DW-1:0] pc;
    logic [DW-1:0] alu_res;
    logic [DW-1:0] mem_data;
    logic          wb_en;
    logic          mem_to_reg;
    logic [AW-1:0] wb_dest;
`ifdef MEM_WB_PERF_CNT_EN
    logic [31:0]   stall_cnt;
    logic [31:0]   bubble_cnt;
`endif

    mem_wb_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr_in(instr_in), .pc_in(pc_in), .alu_res_in(alu_res_in),
        .mem_data_in(mem_data_in), .wb_en_in(wb_en_in),
        .mem_to_reg_in(mem_to_reg_in), .wb_dest_in(wb_dest_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .pc(pc), .alu_res(alu_res), .mem_data(mem_data),
        .wb_en(wb_en), .mem_to_reg(mem_to_reg), .wb_dest(wb_dest)
`ifdef MEM_WB_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a queue holding at most two bundles in arrival order.
    logic [BW-1:0] model_q[$];
    bit            model_ok = 1'b0;
    logic [BW-1:0] in_bundle;
    assign in_bundle = {instr_in, pc_in, alu_res_in, mem_data_in, wb_en_in, mem_to_reg_in, wb_dest_in};

    always @(posedge clk) begin
        bit m_acc;
        bit m_drn;
        if (rst) begin
            model_q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            m_acc = in_valid && (model_q.size() < 2);
            m_drn = (model_q.size() > 0) && out_ready;
            if (flush) begin
                model_q.delete();
            end else begin
                if (m_drn) void'(model_q.pop_front());
                if (m_acc) model_q.push_back(in_bundle);
            end
        end
    end

    always @(negedge clk) begin
        logic [BW-1:0] exp_b;
        if (model_ok) begin
            exp_b = (model_q.size() > 0) ? model_q[0] : '0;
            chk("cyc_out_valid", BW'(out_valid), BW'(model_q.size() > 0));
            chk("cyc_in_ready", BW'(in_ready), BW'(model_q.size() < 2));
            chk("cyc_bundle", {instr, pc, alu_res, mem_data, wb_en, mem_to_reg, wb_dest}, exp_b);
        end
    end

    // Records instructions handed to WB during the streaming test.
    bit            rec_en = 1'b0;
    logic [DW-1:0] rx[$];
    always @(posedge clk) begin
        if (rec_en && !rst && out_valid && out_ready) rx.push_back(instr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] i, input logic [DW-1:0] p, input logic [DW-1:0] a,
                         input logic [DW-1:0] m, input logic we, input logic m2r, input logic [AW-1:0] d);
        instr_in = i; pc_in = p; alu_res_in = a; mem_data_in = m;
        wb_en_in = we; mem_to_reg_in = m2r; wb_dest_in = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        bit did_acc;

        // Reset held for two cycles
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_in_ready", BW'(in_ready), BW'(1));
        chk("rst_instr", BW'(instr), BW'(0));
        chk("rst_wb_en", BW'(wb_en), BW'(0));
        rst = 1'b0;

        // Single transfer, one-cycle latency
        out_ready = 1'b1;
        in_valid = 1'b1;
        drive(32'hE3A0_1005, 32'h0000_0100, 32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd1);
        tick();
        chk("lat_out_valid", BW'(out_valid), BW'(1));
        chk("lat_instr", BW'(instr), BW'(32'hE3A0_1005));
        chk("lat_mem_data", BW'(mem_data), BW'(32'hDEAD_BEEF));
        chk("lat_wb_dest", BW'(wb_dest), BW'(5'd1));
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", BW'(out_valid), BW'(0));

        // Skid: A, B pushed with WB stalled, then released
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(32'd1, 32'd4, 32'd11, 32'd21, 1'b1, 1'b1, 5'd3);
        tick();
        drive(32'd2, 32'd8, 32'd12, 32'd22, 1'b0, 1'b0, 5'd4);
        tick();
        in_valid = 1'b0;
        chk("skid_in_ready", BW'(in_ready), BW'(0));
        chk("skid_hold_a", BW'(instr), BW'(1));
        tick();
        chk("skid_stable_a", BW'(instr), BW'(1));
        out_ready = 1'b1;
        tick();
        chk("skid_b_instr", BW'(instr), BW'(2));
        chk("skid_b_valid", BW'(out_valid), BW'(1));
        chk("skid_b_in_ready", BW'(in_ready), BW'(1));
        tick();
        chk("skid_empty", BW'(out_valid), BW'(0));

        // Flush while full, C presented the same cycle
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd5);
        tick();
        drive(32'h11, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd6);
        tick();
        drive(32'd3, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush2_out_valid", BW'(out_valid), BW'(0));
        chk("flush2_in_ready", BW'(in_ready), BW'(1));
        out_ready = 1'b1;
        tick();
        chk("flush2_no_c", BW'(out_valid), BW'(0));

        // Flush beats a same-cycle accept while one entry is held
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(32'h20, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd8);
        tick();
        drive(32'd4, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush1_out_valid", BW'(out_valid), BW'(0));
        chk("flush1_instr", BW'(instr), BW'(0));

        // Reset mid-transfer discards the held bundle
        in_valid = 1'b1;
        drive(32'h77, 32'h1, 32'h2, 32'h3, 1'b1, 1'b1, 5'd10);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", BW'(out_valid), BW'(0));
        chk("midrst_instr", BW'(instr), BW'(0));
`ifdef MEM_WB_PERF_CNT_EN
        chk("perf_rst_stall", BW'(stall_cnt), BW'(0));
        chk("perf_rst_bubble", BW'(bubble_cnt), BW'(0));
        repeat (3) tick();
        in_valid = 1'b1;
        drive(32'h88, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 5'd11);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("perf_stall5", BW'(stall_cnt), BW'(5));
        chk("perf_bubble_ge3", BW'(bubble_cnt >= 32'd3), BW'(1));
        chk("perf_bubble4", BW'(bubble_cnt), BW'(4));
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("perf_flush_stall", BW'(stall_cnt), BW'(5));
        chk("perf_flush_bubble", BW'(bubble_cnt), BW'(4));
`endif

        // Stream 100 bundles with random WB back-pressure
        sent = 0;
        rec_en = 1'b1;
        for (int cyc = 0; cyc < 3000 && rx.size() < 100; cyc++) begin
            if (sent < 100) begin
                in_valid = 1'b1;
                drive(32'h1000 + sent, sent * 4, ~sent, sent ^ 32'hA5A5_A5A5,
                      sent[0], sent[1], sent[AW-1:0]);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            did_acc = in_valid && in_ready;
            tick();
            if (did_acc) sent++;
        end
        rec_en = 1'b0;
        in_valid = 1'b0;
        chk("stream_count", BW'(rx.size()), BW'(100));
        for (int i = 0; i < rx.size() && i < 100; i++) begin
            chk("stream_order", BW'(rx[i]), BW'(32'h1000 + i));
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
